// File: rtl/n64adv2_joybus_sniffer.sv
// n64adv2_joybus_sniffer: passive Joybus poll/response decoder per port with toggle-ack
// handshake and a timed in-game-reset request on a selectable port.
module n64adv2_joybus_sniffer #(
  parameter int          NUM_PORTS  = 1,
  parameter int          CNT_W      = 8,
  parameter int          IGR_PORT   = 0,
  parameter logic [15:0] IGR_COMBO  = 16'h0000,
  parameter logic [19:0] RST_CYCLES = 20'hFFFFF
) (
  input  logic                    CTRL_CLK,
  input  logic                    CTRL_nRST,
  input  logic [NUM_PORTS-1:0]    ctrl_i,
  input  logic [NUM_PORTS-1:0]    ack_tgl_i,
  input  logic                    igr_en_i,
  output logic [32*NUM_PORTS-1:0] data_o,
  output logic [NUM_PORTS-1:0]    new_data_o,
  output logic [NUM_PORTS-1:0]    overrun_o,
  output logic                    rst_req_o
);
  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;
  logic        igr_hit;
  logic [19:0] rst_cnt;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    state_t           state;
    logic [2:0]       hist;
    logic [CNT_W-1:0] cnt, low_cnt;
    logic [7:0]       cmd;
    logic [30:0]      sh;
    logic [5:0]       bcnt;
    logic [1:0]       ack_q;
    logic [31:0]      data, word;
    logic             nd, ovr, ne, pe, sat, b, ack, cap;
    assign ne   = hist[2] & ~hist[1];
    assign pe   = ~hist[2] & hist[1];
    assign sat  = &cnt;
    // a bit is 1 when its low phase is shorter than its high phase
    assign b    = low_cnt < cnt;
    assign ack  = ack_q[1] ^ ack_q[0];
    assign word = {b, sh};
    assign cap  = state == RESP && !sat && ne && bcnt == 6'd31;
    assign data_o[32*p +: 32] = data;
    assign new_data_o[p] = nd;
    assign overrun_o[p]  = ovr;
    if (p == IGR_PORT) begin : g_igr
      assign igr_hit = igr_en_i && cap && word[15:0] == IGR_COMBO;
    end
    always_ff @(posedge CTRL_CLK or negedge CTRL_nRST)
      if (!CTRL_nRST) begin
        state   <= IDLE;
        hist    <= 3'b111;
        cnt     <= '0;
        low_cnt <= '0;
        cmd     <= '0;
        sh      <= '0;
        bcnt    <= '0;
        ack_q   <= '0;
        data    <= '0;
        nd      <= 1'b0;
        ovr     <= 1'b0;
      end else begin
        hist  <= {hist[1:0], ctrl_i[p]};
        ack_q <= {ack_q[0], ack_tgl_i[p]};
        cnt   <= (ne | pe) ? '0 : sat ? cnt : cnt + 1'b1;
        if (pe) low_cnt <= cnt;
        // a capture in the same cycle as an ack wins and is not an overrun
        if (cap) begin
          data <= word;
          nd   <= 1'b1;
          if (nd && !ack) ovr <= 1'b1;
        end else if (ack) nd <= 1'b0;
        if (state != IDLE && sat) state <= IDLE;
        else if (ne)
          case (state)
            IDLE: if (sat) begin
              state <= CMD;
              cmd   <= '0;
              bcnt  <= '0;
            end
            CMD: if (bcnt == 6'd8) begin
              state <= (cmd == 8'h01) ? RESP : IDLE;
              bcnt  <= '0;
            end else begin
              cmd  <= {cmd[6:0], b};
              bcnt <= bcnt + 1'b1;
            end
            RESP: begin
              sh    <= word[31:1];
              bcnt  <= bcnt + 1'b1;
              state <= (bcnt == 6'd31) ? IDLE : RESP;
            end
            default: state <= IDLE;
          endcase
      end
  end
  always_ff @(posedge CTRL_CLK or negedge CTRL_nRST)
    if (!CTRL_nRST) begin
      rst_cnt   <= '0;
      rst_req_o <= 1'b0;
    end else if (igr_hit) begin
      rst_cnt   <= RST_CYCLES;
      rst_req_o <= 1'b1;
    end else if (|rst_cnt) rst_cnt <= rst_cnt - 1'b1;
    else rst_req_o <= 1'b0;
endmodule
